// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-PC selection for the MIPS32 fetch stage.
// Replaces the branch AND gate and the PC+4/branch and jump muxes, and adds
// jump-register, stall hold and a post-reset boot cycle.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a redirect target with bits [1:0] != 0 traps to TRAP_VECTOR,
//               recording the trapping pc in epc.
//   undefined : target bits [1:0] are forced to 00; trap and epc are tied 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle after reset; pc holds RESET_VECTOR, nothing fetched
// RUN   | normal fetch; pc advances or redirects unless stalled
// TRAP  | (MISALIGN_TRAP_EN only) pc = TRAP_VECTOR, trap pulse, no fetch

module pc_sequencer #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch,
    input  logic             zero,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic             redirect,
    output logic             trap,
    output logic [WIDTH-1:0] epc
);

    // Vectors must be word aligned and the jump field assumes at least 32 bits.
    if (WIDTH < 32 || RESET_VECTOR[1:0] != 2'b00 || TRAP_VECTOR[1:0] != 2'b00) begin : g_param_check
        $error("pc_sequencer: WIDTH must be >= 32 and vectors word aligned");
    end

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);

`ifdef MISALIGN_TRAP_EN
    localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] jump_addr;
    logic [WIDTH-1:0] branch_addr;
    logic [WIDTH-1:0] target;
    logic             taken_branch;

    assign pc_plus4     = pc + WIDTH'(4);
    assign jump_addr    = {pc_plus4[WIDTH-1:28], jump_target, 2'b00};
    assign branch_addr  = pc_plus4 + (branch_off << 2);
    assign taken_branch = branch & zero;

    // Redirect target by fixed priority jr > jump > taken branch.
    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        if (jr) begin
            target = jr_addr;
        end else if (jump) begin
            target = jump_addr;
        end else if (taken_branch) begin
            target = branch_addr;
        end
        redirect = (state == ST_RUN) && (jr || jump || taken_branch);
    end

`ifdef MISALIGN_TRAP_EN
    logic [WIDTH-1:0] next_epc;

    // Next-state and next-pc selection; a misaligned target diverts to TRAP.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_epc   = epc;
        case (state)
            ST_BOOT: next_state = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    if (redirect) begin
                        if (target[1:0] != 2'b00) begin
                            next_state = ST_TRAP;
                            next_epc   = pc;
                            next_pc    = TRAP_PC;
                        end else begin
                            next_pc = target;
                        end
                    end else begin
                        next_pc = pc_plus4;
                    end
                end
            end
            // pc already sits at TRAP_PC; it is fetched on the return to RUN.
            ST_TRAP: next_state = ST_RUN;
            default: next_state = ST_BOOT;
        endcase
    end

    // Trap bookkeeping: epc capture and the one-cycle trap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc  <= '0;
            trap <= 1'b0;
        end else begin
            epc  <= next_epc;
            trap <= (next_state == ST_TRAP);
        end
    end
`else
    // Next-state and next-pc selection; misaligned targets are word aligned.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        case (state)
            ST_BOOT: next_state = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    if (redirect) begin
                        next_pc = target & ~WIDTH'(3);
                    end else begin
                        next_pc = pc_plus4;
                    end
                end
            end
            default: next_state = ST_BOOT;
        endcase
    end

    assign epc  = '0;
    assign trap = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= next_state;
        end
    end

    // PC register and fetch-valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
        end else begin
            pc       <= next_pc;
            pc_valid <= (next_state == ST_RUN);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a behavioural next-PC model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branch_off;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        redirect;
    logic        trap;
    logic [31:0] epc;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = booting, 1 = running, 2 = trap cycle
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    int          m_mode;

    pc_sequencer #(
        .WIDTH(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0180)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch(branch),
        .zero(zero),
        .branch_off(branch_off),
        .jump(jump),
        .jump_target(jump_target),
        .jr(jr),
        .jr_addr(jr_addr),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .pc_valid(pc_valid),
        .redirect(redirect),
        .trap(trap),
        .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall       = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        branch_off  = 32'h0;
        jump        = 1'b0;
        jump_target = 26'h0;
        jr          = 1'b0;
        jr_addr     = 32'h0;
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_epc  = 32'h0;
        m_mode = 0;
    endtask

    // Apply one clock edge of the rules to the model using current inputs.
    task automatic model_tick();
        logic [31:0] seq;
        logic [31:0] tgt;
        bit          take;
        seq = m_pc + 32'd4;
        if (m_mode != 1) begin
            m_mode = 1;
        end else if (!stall) begin
            take = 1'b1;
            if (jr)                  tgt = jr_addr;
            else if (jump)           tgt = {seq[31:28], jump_target, 2'b00};
            else if (branch && zero) tgt = seq + branch_off * 32'd4;
            else begin
                tgt  = seq;
                take = 1'b0;
            end
`ifdef MISALIGN_TRAP_EN
            if (take && tgt[1:0] != 2'b00) begin
                m_epc  = m_pc;
                m_pc   = 32'h180;
                m_mode = 2;
            end else begin
                m_pc = tgt;
            end
`else
            m_pc = take ? {tgt[31:2], 2'b00} : tgt;
`endif
        end
    endtask

    task automatic clk_step();
        model_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_pc(input logic [31:0] addr);
        clear_inputs();
        jr      = 1'b1;
        jr_addr = addr;
        clk_step();
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap got=%b exp=0", trap); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", epc); end
        @(negedge clk);
        rst = 1'b0;
        clk_step();
        total++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin bad++; $display("FAIL boot_first pc=%h valid=%b exp pc=0 valid=1", pc, pc_valid); end
        set_pc(32'h40);
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL load_40 got=%h exp=40", pc); end
        // asynchronous reset in the middle of a cycle
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin bad++; $display("FAIL async_reset pc=%h valid=%b exp pc=0 valid=0", pc, pc_valid); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL boot_cycle valid=%b exp=0", pc_valid); end
        clk_step();
        total++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin bad++; $display("FAIL run_0 pc=%h valid=%b exp pc=0 valid=1", pc, pc_valid); end
        clk_step();
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL run_4 got=%h exp=4", pc); end
        clk_step();
        total++; if (pc !== 32'h8) begin bad++; $display("FAIL run_8 got=%h exp=8", pc); end
    endtask

    task automatic test_branch();
        set_pc(32'h100);
        branch = 1'b1; zero = 1'b1; branch_off = 32'hFFFF_FFFE;
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL branch_redirect got=%b exp=1", redirect); end
        clk_step();
        total++; if (pc !== 32'hFC) begin bad++; $display("FAIL branch_taken got=%h exp=fc", pc); end
        set_pc(32'h100);
        branch = 1'b1; zero = 1'b0; branch_off = 32'hFFFF_FFFE;
        #1;
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL branch_nt_redirect got=%b exp=0", redirect); end
        clk_step();
        total++; if (pc !== 32'h104) begin bad++; $display("FAIL branch_not_taken got=%h exp=104", pc); end
        clear_inputs();
    endtask

    task automatic test_priority();
        set_pc(32'h500);
        jr = 1'b1; jr_addr = 32'h2000;
        jump = 1'b1; jump_target = 26'h40;
        branch = 1'b1; zero = 1'b1; branch_off = 32'h10;
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL prio_redirect got=%b exp=1", redirect); end
        clk_step();
        total++; if (pc !== 32'h2000) begin bad++; $display("FAIL prio_jr got=%h exp=2000", pc); end
        clear_inputs();
        jump = 1'b1; jump_target = 26'h40;
        branch = 1'b1; zero = 1'b1; branch_off = 32'h10;
        clk_step();
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL prio_jump got=%h exp=100", pc); end
        clear_inputs();
    endtask

    task automatic test_stall();
        set_pc(32'h200);
        stall = 1'b1; jump = 1'b1; jump_target = 26'h80;
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL stall_redirect got=%b exp=1", redirect); end
        for (int i = 0; i < 3; i++) begin
            clk_step();
            total++; if (pc !== 32'h200 || pc_valid !== 1'b1) begin bad++; $display("FAIL stall_hold_%0d pc=%h valid=%b exp pc=200 valid=1", i, pc, pc_valid); end
        end
        stall = 1'b0;
        clk_step();
        total++; if (pc !== 32'h200) begin bad++; $display("FAIL stall_release got=%h exp=200", pc); end
        clear_inputs();
        clk_step();
        total++; if (pc !== 32'h204) begin bad++; $display("FAIL stall_after got=%h exp=204", pc); end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        #1;
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got=%h exp=0", pc_plus4); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL wrap_redirect got=%b exp=0", redirect); end
        clk_step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    endtask

    task automatic test_misalign();
        set_pc(32'h300);
        jr = 1'b1; jr_addr = 32'h1002;
        clk_step();
        clear_inputs();
`ifdef MISALIGN_TRAP_EN
        total++; if (epc !== 32'h300) begin bad++; $display("FAIL mis_epc got=%h exp=300", epc); end
        total++; if (trap !== 1'b1 || pc !== 32'h180 || pc_valid !== 1'b0) begin bad++; $display("FAIL mis_trap trap=%b pc=%h valid=%b exp trap=1 pc=180 valid=0", trap, pc, pc_valid); end
        jr = 1'b1; jr_addr = 32'h4000; stall = 1'b1;
        #1;
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL mis_trap_redirect got=%b exp=0", redirect); end
        clk_step();
        clear_inputs();
        total++; if (trap !== 1'b0 || pc !== 32'h180 || pc_valid !== 1'b1) begin bad++; $display("FAIL mis_fetch trap=%b pc=%h valid=%b exp trap=0 pc=180 valid=1", trap, pc, pc_valid); end
        clk_step();
        total++; if (pc !== 32'h184) begin bad++; $display("FAIL mis_next got=%h exp=184", pc); end
`else
        total++; if (pc !== 32'h1000) begin bad++; $display("FAIL mis_align got=%h exp=1000", pc); end
        total++; if (trap !== 1'b0 || epc !== 32'h0) begin bad++; $display("FAIL mis_notrap trap=%b epc=%h exp trap=0 epc=0", trap, epc); end
        clk_step();
        total++; if (pc !== 32'h1004 || pc_valid !== 1'b1) begin bad++; $display("FAIL mis_next pc=%h valid=%b exp pc=1004 valid=1", pc, pc_valid); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] r;
        bit          exp_redir;
        for (int n = 0; n < 400; n++) begin
            stall       = ($urandom % 4) == 0;
            branch      = ($urandom % 3) == 0;
            zero        = ($urandom % 2) == 0;
            jump        = ($urandom % 6) == 0;
            jr          = ($urandom % 8) == 0;
            branch_off  = 32'($urandom_range(0, 64)) - 32'd32;
            jump_target = 26'($urandom);
            r           = $urandom;
            if ($urandom % 2) r[1:0] = 2'b00;
            jr_addr     = r;
            #1;
            exp_redir = (m_mode == 1) && (jr || jump || (branch && zero));
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, pc, m_pc); end
            total++; if (pc_valid !== (m_mode == 1)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, pc_valid, m_mode == 1); end
            total++; if (trap !== (m_mode == 2)) begin bad++; $display("FAIL rnd_trap[%0d] got=%b exp=%b", n, trap, m_mode == 2); end
            total++; if (epc !== m_epc) begin bad++; $display("FAIL rnd_epc[%0d] got=%h exp=%h", n, epc, m_epc); end
            total++; if (pc_plus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_plus4[%0d] got=%h exp=%h", n, pc_plus4, m_pc + 32'd4); end
            total++; if (redirect !== exp_redir) begin bad++; $display("FAIL rnd_redirect[%0d] got=%b exp=%b", n, redirect, exp_redir); end
            clk_step();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_priority();
        test_stall();
        test_wrap();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
